// File: rtl/sel_status_uart_tx.sv
// Purpose: reports the active pattern select to the host as "<digit>\r\n" over an 8N1 UART line.
// Latency: trigger seen in cycle T drives the start bit from T+1; a message is 30*CLKS_PER_BIT cycles long.
// Backpressure: none; i_report pulses arriving while busy are remembered and replayed as one extra message.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_sel     current pattern select (level)
//   i_report  single-cycle request to resend the current select
//   o_tx      UART serial line, idles high
//   o_busy    high while a message is in flight
//   o_done    one-cycle pulse after the final stop bit of a message
module sel_status_uart_tx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_sel,
    input  logic       i_report,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [1:0]       byte_idx;
    logic [1:0]       shadow;    // select most recently reported
    logic [1:0]       msg_sel;   // select frozen for the message in flight
    logic             pending;   // i_report seen while busy

    logic             trigger;
    logic             bit_end;
    logic [2:0]       bit_nxt;
    logic [7:0]       cur_byte;

    function automatic logic [7:0] encode_sel(input logic [1:0] s);
        logic [7:0] d;
        case (s)
            2'b00:   d = 8'h31;
            2'b01:   d = 8'h32;
            2'b10:   d = 8'h33;
            default: d = 8'h30;  // "off/default"
        endcase
        return d;
    endfunction

    always_comb begin
        trigger = (i_sel != shadow) || i_report || pending;
        bit_end = (baud_cnt == CNT_LAST);
        bit_nxt = bit_idx + 3'd1;
        case (byte_idx)
            2'd0:    cur_byte = encode_sel(msg_sel);
            2'd1:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shadow   <= 2'b11;
            msg_sel  <= 2'b11;
            pending  <= 1'b0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;

            // Every non-idle state is a sequence of CLKS_PER_BIT-wide bit slots.
            if (state != IDLE) begin
                if (i_report) begin
                    pending <= 1'b1;
                end
                baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        msg_sel  <= i_sel;
                        shadow   <= i_sel;
                        pending  <= 1'b0;
                        byte_idx <= 2'd0;
                        baud_cnt <= '0;
                        state    <= START;
                        o_tx     <= 1'b0;
                        o_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= 3'd0;
                        o_tx    <= cur_byte[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            o_tx  <= 1'b1;
                        end else begin
                            bit_idx <= bit_nxt;
                            o_tx    <= cur_byte[bit_nxt];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (byte_idx != 2'd2) begin
                            // next byte follows immediately, no idle gap
                            byte_idx <= byte_idx + 2'd1;
                            state    <= START;
                            o_tx     <= 1'b0;
                        end else begin
                            byte_idx <= 2'd0;
                            state    <= IDLE;
                            o_busy   <= 1'b0;
                            o_done   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sel_status_uart_tx.sv
module tb_sel_status_uart_tx;

    localparam int N = 10;  // clocks per bit at 1 MHz / 100 kBd

    logic       i_clk    = 1'b0;
    logic       i_rst_n  = 1'b0;
    logic [1:0] i_sel    = 2'b11;
    logic       i_report = 1'b0;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    int         errors = 0;
    int         checks = 0;
    logic [1:0] model_shadow = 2'b11;

    // per-step recording, index 1 = first step after stimulus
    logic rec_tx   [0:1023];
    logic rec_busy [0:1023];
    logic rec_done [0:1023];

    sel_status_uart_tx #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sel   (i_sel),
        .i_report(i_report),
        .o_tx    (o_tx),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] enc(input logic [1:0] s);
        return (s == 2'b11) ? 8'h30 : 8'h31 + {6'd0, s};
    endfunction

    // Expected line level for each of the 30 bit slots of "<d>\r\n", 8N1, LSB first.
    function automatic logic [29:0] frame_bits(input logic [7:0] d);
        logic [7:0]  bs [3];
        logic [29:0] fb;
        bs[0] = d;
        bs[1] = 8'h0D;
        bs[2] = 8'h0A;
        for (int j = 0; j < 3; j++) begin
            fb[j*10] = 1'b0;
            for (int i = 0; i < 8; i++) fb[j*10+1+i] = bs[j][i];
            fb[j*10+9] = 1'b1;
        end
        return fb;
    endfunction

    // Mismatching cycles of a whole message whose first start-bit step is 'start'.
    function automatic int msg_err(input int start, input logic [7:0] d);
        logic [29:0] fb;
        int          e;
        fb = frame_bits(d);
        e  = 0;
        for (int k = 0; k < 30*N; k++)
            if (rec_tx[start+k] !== fb[k/N] || rec_busy[start+k] !== 1'b1 || rec_done[start+k] !== 1'b0)
                e++;
        return e;
    endfunction

    // UART-receiver view: sample byte j of the message at mid-bit.
    function automatic logic [7:0] decode(input int start, input int j);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = rec_tx[start + (j*10+1+i)*N + N/2];
        return b;
    endfunction

    function automatic int done_count(input int from, input int to);
        int c;
        c = 0;
        for (int k = from; k <= to; k++) if (rec_done[k] === 1'b1) c++;
        return c;
    endfunction

    // Step n cycles recording outputs; optional action after sampling step act_step.
    task automatic capture(input int n, input int act_step, input int act_kind, input logic [1:0] act_val);
        for (int k = 1; k <= n; k++) begin
            @(negedge i_clk);
            rec_tx[k]   = o_tx;
            rec_busy[k] = o_busy;
            rec_done[k] = o_done;
            i_report    = 1'b0;
            if (k == act_step) begin
                if (act_kind == 1) i_sel = act_val;
                else if (act_kind == 2) i_report = 1'b1;
            end
        end
        i_report = 1'b0;
    endtask

    task automatic settle_sel(input logic [1:0] s);
        i_sel = s;
        if (model_shadow != s) begin
            capture(320, 0, 0, 2'b00);
            model_shadow = s;
        end
    endtask

    function automatic logic [1:0] pick_new_sel();
        logic [1:0] s;
        do s = 2'($urandom_range(0, 3)); while (s == model_shadow);
        return s;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int bad;
        i_rst_n = 1'b0;
        i_sel   = 2'b11;
        repeat (3) @(negedge i_clk);
        checks++; if (o_tx !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b want 1", o_tx); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
        i_rst_n = 1'b1;
        capture(1000, 0, 0, 2'b00);
        bad = 0;
        for (int k = 1; k <= 1000; k++)
            if (rec_tx[k] !== 1'b1 || rec_busy[k] !== 1'b0 || rec_done[k] !== 1'b0) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL reset_idle: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_select_change();
        logic [1:0] s;
        logic [7:0] d;
        for (int it = 0; it < 4; it++) begin
            s = (it == 0) ? 2'b00 : pick_new_sel();
            d = enc(s);
            i_sel = s;
            capture(320, 0, 0, 2'b00);
            checks++; if (decode(1, 0) !== d)     begin errors++; $display("FAIL sel_byte0: got %h want %h", decode(1, 0), d); end
            checks++; if (decode(1, 1) !== 8'h0D) begin errors++; $display("FAIL sel_byte1: got %h want 0d", decode(1, 1)); end
            checks++; if (decode(1, 2) !== 8'h0A) begin errors++; $display("FAIL sel_byte2: got %h want 0a", decode(1, 2)); end
            checks++; if (msg_err(1, d) !== 0)    begin errors++; $display("FAIL sel_wave: got %0d bad cycles want 0", msg_err(1, d)); end
            checks++;
            if (rec_done[301] !== 1'b1 || rec_busy[301] !== 1'b0 || rec_tx[301] !== 1'b1) begin
                errors++;
                $display("FAIL sel_done_301: got done=%b busy=%b tx=%b want 1 0 1", rec_done[301], rec_busy[301], rec_tx[301]);
            end
            checks++; if (done_count(1, 320) !== 1) begin errors++; $display("FAIL sel_done_once: got %0d want 1", done_count(1, 320)); end
            model_shadow = s;
        end
    endtask

    task automatic test_forced_report();
        int act;
        settle_sel(2'b10);
        capture(50, 0, 0, 2'b00);
        act = 0;
        for (int k = 1; k <= 50; k++) if (rec_busy[k] !== 1'b0 || rec_tx[k] !== 1'b1) act++;
        checks++; if (act !== 0) begin errors++; $display("FAIL report_quiet: got %0d active cycles want 0", act); end
        i_report = 1'b1;
        capture(320, 0, 0, 2'b00);
        checks++; if (decode(1, 0) !== 8'h33) begin errors++; $display("FAIL report_byte0: got %h want 33", decode(1, 0)); end
        checks++; if (msg_err(1, 8'h33) !== 0) begin errors++; $display("FAIL report_wave: got %0d bad cycles want 0", msg_err(1, 8'h33)); end
        checks++; if (done_count(1, 320) !== 1 || rec_done[301] !== 1'b1) begin
            errors++; $display("FAIL report_done: got count=%0d at301=%b want 1 1", done_count(1, 320), rec_done[301]);
        end
    endtask

    task automatic test_change_mid();
        settle_sel(2'b11);
        i_sel = 2'b01;
        capture(650, 50, 1, 2'b10);
        checks++; if (msg_err(1, 8'h32) !== 0)   begin errors++; $display("FAIL mid_first_wave: got %0d bad cycles want 0", msg_err(1, 8'h32)); end
        checks++; if (rec_done[301] !== 1'b1)    begin errors++; $display("FAIL mid_first_done: got %b want 1", rec_done[301]); end
        checks++; if (rec_tx[301] !== 1'b1)      begin errors++; $display("FAIL mid_gap_idle: got %b want 1", rec_tx[301]); end
        checks++; if (decode(302, 0) !== 8'h33)  begin errors++; $display("FAIL mid_second_byte0: got %h want 33", decode(302, 0)); end
        checks++; if (msg_err(302, 8'h33) !== 0) begin errors++; $display("FAIL mid_second_wave: got %0d bad cycles want 0", msg_err(302, 8'h33)); end
        checks++; if (done_count(1, 650) !== 2 || rec_done[602] !== 1'b1) begin
            errors++; $display("FAIL mid_done: got count=%0d at602=%b want 2 1", done_count(1, 650), rec_done[602]);
        end
        model_shadow = 2'b10;
    endtask

    task automatic test_report_busy();
        logic [1:0] s;
        logic [7:0] d;
        int         r;
        int         act;
        for (int it = 0; it < 2; it++) begin
            s = pick_new_sel();
            d = enc(s);
            r = (it == 0) ? 120 : $urandom_range(2, 299);
            i_sel = s;
            capture(950, r, 2, 2'b00);
            act = 0;
            for (int k = 603; k <= 950; k++) if (rec_busy[k] !== 1'b0 || rec_tx[k] !== 1'b1) act++;
            checks++; if (msg_err(1, d) !== 0)   begin errors++; $display("FAIL busy_first_wave r=%0d: got %0d bad want 0", r, msg_err(1, d)); end
            checks++; if (msg_err(302, d) !== 0) begin errors++; $display("FAIL busy_followup_wave r=%0d: got %0d bad want 0", r, msg_err(302, d)); end
            checks++; if (done_count(1, 950) !== 2) begin errors++; $display("FAIL busy_done_count r=%0d: got %0d want 2", r, done_count(1, 950)); end
            checks++; if (act !== 0) begin errors++; $display("FAIL busy_no_third r=%0d: got %0d active cycles want 0", r, act); end
            model_shadow = s;
        end
    endtask

    task automatic test_report_and_change();
        logic [1:0] s;
        s = pick_new_sel();
        i_sel    = s;
        i_report = 1'b1;
        capture(650, 0, 0, 2'b00);
        checks++; if (msg_err(1, enc(s)) !== 0) begin errors++; $display("FAIL same_cycle_wave: got %0d bad want 0", msg_err(1, enc(s))); end
        checks++; if (done_count(1, 650) !== 1) begin errors++; $display("FAIL same_cycle_once: got %0d want 1", done_count(1, 650)); end
        model_shadow = s;
    endtask

    task automatic test_reset_mid();
        logic [29:0] fb;
        int          k;
        fb = frame_bits(enc(model_shadow));
        do k = $urandom_range(12, 89); while (fb[(k-1)/N] !== 1'b0 || (k-1)/N < 1);
        i_report = 1'b1;
        capture(k, 0, 0, 2'b00);
        checks++; if (rec_tx[k] !== 1'b0 || rec_busy[k] !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got tx=%b busy=%b want 0 1", rec_tx[k], rec_busy[k]);
        end
        i_sel   = 2'b00;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_tx !== 1'b1)   begin errors++; $display("FAIL rstmid_tx: got %b want 1", o_tx); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", o_done); end
        repeat (2) @(negedge i_clk);
        model_shadow = 2'b11;
        i_rst_n = 1'b1;
        capture(320, 0, 0, 2'b00);
        checks++; if (decode(1, 0) !== 8'h31) begin errors++; $display("FAIL rstmid_byte0: got %h want 31", decode(1, 0)); end
        checks++; if (decode(1, 1) !== 8'h0D) begin errors++; $display("FAIL rstmid_byte1: got %h want 0d", decode(1, 1)); end
        checks++; if (decode(1, 2) !== 8'h0A) begin errors++; $display("FAIL rstmid_byte2: got %h want 0a", decode(1, 2)); end
        checks++; if (msg_err(1, 8'h31) !== 0 || rec_done[301] !== 1'b1) begin
            errors++; $display("FAIL rstmid_wave: got %0d bad, done301=%b want 0 1", msg_err(1, 8'h31), rec_done[301]);
        end
        model_shadow = 2'b00;
    endtask

    initial begin
        test_reset();
        test_select_change();
        test_forced_report();
        test_change_mid();
        test_report_busy();
        test_report_and_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sel_status_uart_tx.md
# sel_status_uart_tx

- Reports the currently active LED pattern select back to the host PC over the UART TX line.
- Encodes the 2-bit select into an ASCII digit, then serializes a 3-byte message: digit, 0x0D, 0x0A (8N1 framing).
- Sits beside the UART receiver / pattern-select decoder. Together they form a command/acknowledge loop with the terminal.

## Interface
Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 868 at defaults): clock cycles per bit. Must be ≥ 2.

Ports:
- i_clk, input, 1: system clock. All logic is on the rising edge.
- i_rst_n, input, 1: asynchronous, active-low reset.
- i_sel, input, 2: current pattern select (level), synchronous to i_clk.
- i_report, input, 1: single-cycle request to transmit the current select even if it is unchanged.
- o_tx, output, 1: UART serial output. Idles high.
- o_busy, output, 1: high while a message is in flight.
- o_done, output, 1: single-cycle pulse when the last stop bit of a message completes.

## Operation
- Encoding (i_sel is captured at trigger time):
  - 00 → 0x31 ('1')
  - 01 → 0x32 ('2')
  - 10 → 0x33 ('3')
  - 11 → 0x30 ('0', meaning "off/default")
- Message: byte0 = encoded digit, byte1 = 0x0D, byte2 = 0x0A.
- Frame per byte: start bit 0, data bits LSB first, stop bit 1.
- State tracking:
  - A 2-bit shadow register holds the select most recently reported. Reset value is 2'b11.
  - A pending flag records an i_report pulse that arrives while busy.
- Trigger, evaluated only in IDLE: (i_sel != shadow) OR i_report OR pending.
  - On trigger: latch i_sel into the message register, copy it into shadow, clear pending, set byte index to 0, go to START.
- An i_report pulse during any non-IDLE state sets pending.
- A change of i_sel during transmission does not alter the message in flight. It is picked up by the shadow compare once the FSM returns to IDLE.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx = 1. Enters START on trigger.
  - START: o_tx = 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: o_tx = byte[bit index], each bit held CLKS_PER_BIT cycles.
    - Bit index counts 0..7.
    - After bit 7 the FSM goes to STOP.
  - STOP: o_tx = 1 for CLKS_PER_BIT cycles.
    - If byte index < 2: increment byte index and go to START, with no extra idle cycle.
    - Otherwise go to IDLE and pulse o_done.
- Counters:
  - Baud counter: width clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
  - Bit index: 3 bits.
  - Byte index: 2 bits. Values above 2 never occur.
- o_busy = (state != IDLE).
- Reset, including mid-frame:
  - o_tx = 1, o_busy = 0, o_done = 0.
  - State IDLE, all counters 0, shadow = 2'b11, pending = 0.
  - Takes effect immediately (asynchronous). The partial frame is abandoned.

## Timing
- Trigger seen in cycle T: o_tx = 0 and o_busy = 1 from cycle T+1 (registered outputs).
- Each bit is exactly CLKS_PER_BIT cycles wide.
- One message = 30 × CLKS_PER_BIT cycles: from the first start-bit cycle to the last stop-bit cycle inclusive.
- o_done is high for exactly one cycle, the cycle after the final stop bit. In that same cycle o_busy = 0 and the state is IDLE.
- A new trigger is evaluated in the o_done cycle at the earliest. Minimum idle high time between messages is therefore 1 cycle.
- i_report and an i_sel change in the same IDLE cycle produce exactly one message.
- An i_report held high for several cycles in IDLE produces one message per trigger evaluation. Callers must pulse it.
- Out of reset with i_sel = 2'b11: no message is sent until i_sel changes or i_report pulses.

## Test plan
All scenarios use CLK_FREQ = 1_000_000, BAUD = 100_000, so CLKS_PER_BIT = 10.
- **Reset idle:** hold i_rst_n = 0, then release with i_sel = 11 → o_tx stays 1, o_busy 0, no o_done for 1000 cycles.
- **Select change:** i_sel 11 → 00 → line decodes 0x31, 0x0D, 0x0A in 300 cycles. o_done pulses once, 301 cycles after the change.
- **Forced report:** i_sel = 10, already reported; pulse i_report → bytes 0x33, 0x0D, 0x0A.
- **Change mid-message:** i_sel 11 → 01, then 01 → 10 at cycle 50 of the message → first message 0x32, 0x0D, 0x0A; second message 0x33, 0x0D, 0x0A starts 1 cycle after o_done.
- **Report while busy:** pulse i_report at cycle 120 of a message → exactly one follow-up message carrying the unchanged select.
- **Reset mid-frame:** assert i_rst_n = 0 during a DATA bit → o_tx goes 1 asynchronously. After release with i_sel = 00 a complete new message (0x31, 0x0D, 0x0A) is sent, because the shadow reset to 11.
